alu_iterative: RTL and testbench

ALU_ITERATIVE -- requirements
Module: alu_iterative

---
 rtl/alu_iterative.sv | 157 +++++++++++++++
 tb/tb_alu_iterative.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// alu_iterative: multi-cycle ALU. Logic/arithmetic/compare ops complete in one
// cycle. Shifts step the working register one bit per cycle, so their latency
// tracks the shift amount.
//
// Ports:
//   clk     - clock; all state updates on the rising edge
//   reset   - synchronous, active-high; aborts any operation in progress
//   start   - request, sampled only in the idle state
//   Control - 4-bit operation code
//   A1, A2  - operands; shift amount is A2[SHW-1:0]
//   busy    - high while a shift is stepping
//   done    - one-cycle pulse; Result/Zero/err valid
//   Result  - result, held until the next done
//   Zero    - Result == 0, updated together with Result
//   err     - illegal Control code, reported with done
module alu_iterative #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       Control,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             err
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSll  = 4'b0011;
  localparam logic [3:0] OpSlt  = 4'b0100;
  localparam logic [3:0] OpSltu = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpXor  = 4'b0111;
  localparam logic [3:0] OpSrl  = 4'b1000;
  localparam logic [3:0] OpSra  = 4'b1010;

  typedef enum logic [1:0] {StIdle, StShift, StFin} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] alu_val;
  logic             legal;
  logic             is_shift;
  logic [WIDTH-1:0] shifted;
  logic [SHW-1:0]   shamt;

  assign shamt = A2[SHW-1:0];

  // Single-cycle result, decoded straight from the inputs at the start edge.
  always_comb begin
    alu_val  = '0;
    legal    = 1'b1;
    is_shift = 1'b0;
    case (Control)
      OpAnd:  alu_val = A1 & A2;
      OpOr:   alu_val = A1 | A2;
      OpAdd:  alu_val = A1 + A2;
      OpSub:  alu_val = A1 - A2;
      OpXor:  alu_val = A1 ^ A2;
      OpSlt:  alu_val = {{(WIDTH-1){1'b0}}, $signed(A1) < $signed(A2)};
      OpSltu: alu_val = {{(WIDTH-1){1'b0}}, A1 < A2};
      OpSll, OpSrl, OpSra: begin
        is_shift = 1'b1;
        alu_val  = A1; // zero shift amount passes A1 through
      end
      default: legal = 1'b0;
    endcase
  end

  // One-bit step of the captured shift operation.
  always_comb begin
    case (ctrl_q)
      OpSll:   shifted = {work_q[WIDTH-2:0], 1'b0};
      OpSra:   shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shifted = {1'b0, work_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    ctrl_d   = ctrl_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          work_d = A1;
          ctrl_d = Control;
          cnt_d  = shamt;
          if (is_shift && (shamt != '0)) begin
            state_d = StShift;
          end else begin
            state_d  = StFin;
            result_d = legal ? alu_val : '0;
            zero_d   = legal ? (alu_val == '0) : 1'b1;
            err_d    = ~legal;
          end
        end
      end
      StShift: begin
        work_d = shifted;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d  = StFin;
          result_d = shifted;
          zero_d   = (shifted == '0);
          err_d    = 1'b0;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      work_q   <= '0;
      ctrl_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == StShift);
  assign done   = (state_q == StFin);
  assign Result = result_q;
  assign Zero   = zero_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_alu_iterative;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  Control;
  logic [31:0] A1;
  logic [31:0] A2;
  logic        busy;
  logic        done;
  logic [31:0] Result;
  logic        Zero;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] legal_codes [10] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'hA};

  always #5 clk = ~clk;

  alu_iterative #(.WIDTH(32), .SHW(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .Control (Control),
    .A1      (A1),
    .A2      (A2),
    .busy    (busy),
    .done    (done),
    .Result  (Result),
    .Zero    (Zero),
    .err     (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: result, error flag and cycles from start to done.
  task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    e   = 1'b0;
    lat = 1;
    case (c)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a + b;
      4'h6: r = a - b;
      4'h7: r = a ^ b;
      4'h4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h5: r = (a < b) ? 32'd1 : 32'd0;
      4'h3: begin r = a << sh; lat = 1 + sh; end
      4'h8: begin r = a >> sh; lat = 1 + sh; end
      4'hA: begin r = 32'($signed(a) >>> sh); lat = 1 + sh; end
      default: begin r = 32'd0; e = 1'b1; end
    endcase
  endtask

  // Called at a negedge with the DUT idle. With scramble set, start stays high
  // with changing operands while busy and through the done cycle.
  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble);
    logic [31:0] er;
    logic        ee;
    int          el;
    int          lat;
    model(c, a, b, er, ee, el);
    Control = c;
    A1      = a;
    A2      = b;
    start   = 1'b1;
    @(negedge clk);
    lat = 1;
    if (!scramble) start = 1'b0;
    while (!done && lat <= 40) begin
      check("busy_mid", 32'(busy), 32'd1);
      if (scramble) begin
        A1      = $urandom;
        A2      = $urandom;
        Control = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      lat++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(lat), 32'(el));
    check("result", Result, er);
    check("zero", 32'(Zero), 32'(er == 32'd0));
    check("err", 32'(err), 32'(ee));
    check("busy_fin", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("hold", Result, er);
    if (scramble) begin
      check("no_queue_busy", 32'(busy), 32'd0);
      start = 1'b0;
      @(negedge clk);
      check("no_queue_done", 32'(done), 32'd0);
      check("no_queue_busy2", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int done_cnt;
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;

    reset   = 1'b1;
    start   = 1'b0;
    Control = 4'h0;
    A1      = 32'd0;
    A2      = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_result", Result, 32'd0);
    check("rst_zero", 32'(Zero), 32'd1);

    // start together with reset is dropped
    start   = 1'b1;
    Control = 4'h2;
    A1      = 32'd1;
    A2      = 32'd1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_done", 32'(done), 32'd0);
    @(negedge clk);
    check("rst_start_done2", 32'(done), 32'd0);
    check("rst_start_result", Result, 32'd0);

    // directed corners, issued back to back
    do_op(4'h2, 32'h7FFF_FFFF, 32'd1, 1'b0);
    do_op(4'h6, 32'd5, 32'd5, 1'b0);
    do_op(4'h4, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(4'h5, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(4'hA, 32'h8000_0000, 32'd31, 1'b0);
    do_op(4'h8, 32'h8000_0000, 32'd31, 1'b0);
    do_op(4'h3, 32'd1, 32'd0, 1'b0);
    do_op(4'h3, 32'd1, 32'd4, 1'b1);
    do_op(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    do_op(4'h0, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);

    // reset mid-shift aborts without a done pulse
    Control = 4'h8;
    A1      = $urandom | 32'h8000_0000;
    A2      = 32'd20;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", Result, 32'd0);
    check("abort_zero", 32'(Zero), 32'd1);
    check("abort_err", 32'(err), 32'd0);
    done_cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    do_op(4'h0, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);

    // randomized operations
    repeat (200) begin
      if ($urandom_range(0, 4) == 0) c = 4'($urandom_range(0, 15));
      else c = legal_codes[$urandom_range(0, 9)];
      case ($urandom_range(0, 3))
        0:       begin a = $urandom; b = a; end
        1:       begin a = 32'h8000_0000; b = $urandom; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      do_op(c, a, b, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
